// File: rtl/dsp48_pkg.sv
// Shared DSP48A1-style slice definitions: opmode field encodings, bit indices and datapath widths.
package dsp48_pkg;

    localparam int unsigned P_W     = 48;
    localparam int unsigned M_W     = 36;
    localparam int unsigned S_W     = P_W + 1;
    localparam int unsigned OPM_CIN = 5;
    localparam int unsigned OPM_SUB = 7;

    typedef enum logic [1:0] {
        X_ZERO = 2'd0,
        X_M    = 2'd1,
        X_P    = 2'd2,
        X_DAB  = 2'd3
    } x_sel_e;

    typedef enum logic [1:0] {
        Z_ZERO = 2'd0,
        Z_PCIN = 2'd1,
        Z_P    = 2'd2,
        Z_C    = 2'd3
    } z_sel_e;

endpackage

// File: rtl/dsp_post_adder_acc_if.sv
// Operand/result bundle between the M stage, the post-adder and the cascade/fabric consumers.
interface dsp_post_adder_acc_if;
    import dsp48_pkg::*;

    logic           cep;
    logic           cecarryin;
    logic [M_W-1:0] m_in;
    logic [P_W-1:0] dab_in;
    logic [P_W-1:0] c_in;
    logic [P_W-1:0] pcin;
    logic           carryin;
    logic [7:0]     opmode;
    logic [P_W-1:0] p;
    logic [P_W-1:0] pcout;
    logic           carryout;
    logic           carryoutf;

    modport master (
        output cep, cecarryin, m_in, dab_in, c_in, pcin, carryin, opmode,
        input  p, pcout, carryout, carryoutf
    );

    modport slave (
        input  cep, cecarryin, m_in, dab_in, c_in, pcin, carryin, opmode,
        output p, pcout, carryout, carryoutf
    );

endinterface

// File: rtl/dsp_reg_mux.sv
// Optional pipeline register: sync-reset, clock-enabled flop with a build-time bypass.
module dsp_reg_mux #(
    parameter int unsigned WIDTH = 48,
    parameter bit          REG   = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ce,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_q <= '0;
        end else if (ce) begin
            r_q <= i_d;
        end
    end

    assign o_q = REG ? r_q : i_d;

endmodule

// File: rtl/dsp_post_adder_acc.sv
// Post-adder/accumulator of the DSP slice: X/Z operand muxes, 49-bit add/subtract with carry-in,
// optional P, CYI and CARRYOUT registers, and the PCOUT/CARRYOUTF copies.
module dsp_post_adder_acc
    import dsp48_pkg::*;
#(
    parameter bit PREG        = 1'b1,
    parameter bit CARRYINREG  = 1'b1,
    parameter bit CARRYOUTREG = 1'b1,
    parameter bit CARRYINSEL  = 1'b0
) (
    input logic                 clk,
    input logic                 reset,
    dsp_post_adder_acc_if.slave bus
);

    logic [P_W-1:0] w_p;
    logic [P_W-1:0] w_p_fb;
    logic [P_W-1:0] w_x;
    logic [P_W-1:0] w_z;
    logic [S_W-1:0] w_xc;
    logic [S_W-1:0] w_sum;
    logic           w_cin_raw;
    logic           w_cin;
    logic           w_co;
    logic           w_co_q;
    x_sel_e         w_xsel;
    z_sel_e         w_zsel;

    // Feedback only exists when P is registered; otherwise the loop would be combinational.
    generate
        if (PREG) begin : g_fb
            assign w_p_fb = w_p;
        end else begin : g_no_fb
            assign w_p_fb = '0;
        end
    endgenerate

    assign w_xsel = x_sel_e'(bus.opmode[1:0]);
    assign w_zsel = z_sel_e'(bus.opmode[3:2]);

    always_comb begin
        w_x = '0;
        case (w_xsel)
            X_ZERO:  w_x = '0;
            X_M:     w_x = P_W'(bus.m_in);
            X_P:     w_x = w_p_fb;
            X_DAB:   w_x = bus.dab_in;
            default: w_x = '0;
        endcase
    end

    always_comb begin
        w_z = '0;
        case (w_zsel)
            Z_ZERO:  w_z = '0;
            Z_PCIN:  w_z = bus.pcin;
            Z_P:     w_z = w_p_fb;
            Z_C:     w_z = bus.c_in;
            default: w_z = '0;
        endcase
    end

    assign w_cin_raw = CARRYINSEL ? bus.carryin : bus.opmode[OPM_CIN];

    dsp_reg_mux #(.WIDTH(1), .REG(CARRYINREG)) u_cyi (
        .clk   (clk),
        .reset (reset),
        .ce    (bus.cecarryin),
        .i_d   (w_cin_raw),
        .o_q   (w_cin)
    );

    assign w_xc = {1'b0, w_x} + S_W'(w_cin);

    always_comb begin
        w_sum = {1'b0, w_z} + w_xc;
        if (bus.opmode[OPM_SUB]) begin
            w_sum = {1'b0, w_z} + ~w_xc + S_W'(1);
        end
    end

    // Bit 48 of a subtract is the borrow; the carry output reports it as carry = not-borrow.
    assign w_co = w_sum[P_W] ^ bus.opmode[OPM_SUB];

    dsp_reg_mux #(.WIDTH(P_W), .REG(PREG)) u_preg (
        .clk   (clk),
        .reset (reset),
        .ce    (bus.cep),
        .i_d   (w_sum[P_W-1:0]),
        .o_q   (w_p)
    );

    dsp_reg_mux #(.WIDTH(1), .REG(CARRYOUTREG)) u_coreg (
        .clk   (clk),
        .reset (reset),
        .ce    (bus.cep),
        .i_d   (w_co),
        .o_q   (w_co_q)
    );

    assign bus.p         = w_p;
    assign bus.pcout     = w_p;
    assign bus.carryout  = w_co_q;
    assign bus.carryoutf = w_co_q;

endmodule
